uart_bus_bridge: RTL
====================

Name: uart_bus_bridge

Overview:
- Host-side debug bridge: the bus initiator that drives the memory-mapped peripheral bus from a serial link.
- Consumes bytes from a UART receiver's byte stream and parses command frames.
- Issues single-cycle rd/wr strobes on the peripheral bus (addr/wdata/rdata), then returns response bytes through a UART sender.
- Sits beside the CPU on the peripheral bus; lets a PC peek and poke registers, e.g. the UART and LED registers at 0x4000_00xx.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: inter-byte timeout in clk cycles; mid-frame abort.
- TX_HOLDOFF, 4: cycles after tx_start during which tx_ready is ignored.
- ACK_BYTE, 8'h4B: response byte for a completed write.
- NAK_BYTE, 8'h3F: response byte for an unknown command.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_ready  in  1  high when the sender is idle
- tx_start  out  1  one-cycle pulse: begin sending tx_data
- tx_data  out  8  byte to send; held stable until the next tx_start
- rd  out  1  bus read strobe, one cycle
- wr  out  1  bus write strobe, one cycle
- addr  out  32  bus address
- wdata  out  32  bus write data
- rdata  in  32  bus read data; combinational, valid in the same cycle as rd
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky; rx_valid arrived in a state that cannot accept it

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0; timeout counter 0.
- Frame format (multi-byte fields are MSB first):
  - Write: 8'h57, A3 A2 A1 A0, D3 D2 D1 D0
  - Read: 8'h52, A3 A2 A1 A0
- States:
  - IDLE: on rx_valid, 8'h57 or 8'h52 latches op and goes to ADDR (count=0); any other byte loads NAK_BYTE and goes to RESP with 1 byte.
  - ADDR: each rx_valid shifts a byte into addr (addr <= {addr[23:0],byte}). After the 4th byte, a write goes to DATA and a read goes to BUS.
  - DATA: shifts 4 bytes into wdata the same way, then goes to BUS.
  - BUS: exactly one cycle with wr=1 or rd=1. On rd, rdata is captured into the response shift register in that same cycle. Then goes to RESP: write response is 1 byte (ACK_BYTE); read response is 4 bytes (rdata MSB first).
  - RESP: if tx_ready=1, pulse tx_start for 1 cycle with tx_data set, then go to TX_WAIT.
  - TX_WAIT: count TX_HOLDOFF cycles. Then, once tx_ready=1, go to RESP if bytes remain, otherwise IDLE.
- Latency: the wr/rd strobe occurs exactly 1 cycle after the rx_valid of the last frame byte. The first tx_start occurs ≥1 cycle after the strobe.
- addr and wdata hold their values after the strobe and are not cleared until the next frame.
- Timeout: in ADDR and DATA, the counter increments every cycle and clears on rx_valid. When it reaches TIMEOUT_CYCLES-1, go to IDLE with no bus access and no response.
- rx_valid during BUS, RESP or TX_WAIT: the byte is dropped and overrun <= 1. overrun clears only on reset.
- rx_valid in the same cycle as a timeout expiry: the byte is consumed and the timeout is ignored.
- Asynchronous reset mid-frame or mid-response: immediate return to IDLE with all outputs 0. No partial bus strobe may be produced.
- Byte counter is 2 bits and wraps 3→0 at each field end.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - command constants CMD_WR=8'h57 and CMD_RD=8'h52
  - the state enum IDLE/ADDR/DATA/BUS/RESP/TX_WAIT
  - the default ACK/NAK values.
- One natural sub-module: uart_bridge_resp_shifter. It is a 4-byte parallel-load, MSB-first shift register with a remaining-byte count, and owns tx_data.

Test Plan:
- Write frame 57 40 00 00 0C 00 00 00 A5, each byte 100 cycles apart -> single-cycle wr with addr=32'h4000000C and wdata=32'h000000A5, 1 cycle after the last byte; then one tx_start with tx_data=8'h4B; busy returns to 0.
- Read frame 52 40 00 00 20 with bench rdata=32'h12345678 when addr matches -> single-cycle rd; four tx_start pulses with tx_data 12, 34, 56, 78, each pulse only after tx_ready is high again.
- Byte 8'h00 in IDLE -> no rd/wr; one tx_start with tx_data=8'h3F; back to IDLE.
- 57 40 00, then silence for TIMEOUT_CYCLES (set to 50 in the bench) -> return to IDLE; no strobe, no tx_start; a following valid read frame is then processed correctly.
- rx_valid injected while the 4-byte read response is in TX_WAIT -> overrun=1; the response completes unchanged. Reset asserted mid-response -> tx_start, rd and wr all 0 immediately and overrun cleared.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-peripheral-bus debug bridge:
// command bytes, FSM states and default response bytes.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR      = 8'h57;
  localparam logic [7:0] CMD_RD      = 8'h52;
  localparam logic [7:0] DEFAULT_ACK = 8'h4B;
  localparam logic [7:0] DEFAULT_NAK = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP,
    TX_WAIT
  } bridge_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } bridge_op_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_bridge_resp_shifter.sv
// Response buffer: 4-byte parallel load, MSB-first byte shifter that
// presents each byte on tx_data and tracks how many bytes remain.
module uart_bridge_resp_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic [2:0]  load_count,
  input  logic        shift,
  output logic [7:0]  tx_data,
  output logic [2:0]  remaining
);

  logic [31:0] word;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation order cannot change results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word      <= '0;
      remaining <= '0;
      tx_data   <= '0;
    end else if (load) begin
      word      <= load_word;
      remaining <= load_count;
    end else if (shift && remaining != 3'd0) begin
      // tx_data is registered so it stays put until the next send.
      tx_data   <= word[31:24];
      word      <= {word[23:0], 8'h00};
      remaining <= remaining - 3'd1;
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// Serial debug bridge: parses read/write frames from a UART byte stream,
// issues one-cycle peripheral bus strobes and returns response bytes.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TX_HOLDOFF     = 4,
  parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK,
  parameter logic [7:0]  NAK_BYTE       = DEFAULT_NAK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HO_W = $clog2(TX_HOLDOFF + 2);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(TX_HOLDOFF);

  bridge_state_t   state, state_nx;
  bridge_op_t      op;
  logic [1:0]      byte_cnt;
  logic [TO_W-1:0] idle_cnt;
  logic [HO_W-1:0] hold_cnt;

  logic        field_done, timed_out, hold_done, send;
  logic        load_resp;
  logic [31:0] resp_word;
  logic [2:0]  resp_count, resp_left;

  assign field_done = rx_valid && (byte_cnt == 2'd3);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timed_out  = !rx_valid && (idle_cnt == TO_LAST);
  assign hold_done  = (hold_cnt == HO_LAST);
  assign send       = (state == RESP) && tx_ready;

  // Strobes decode straight from the state register, so an async reset
  // kills them in the same instant and no partial access can escape.
  assign rd   = (state == BUS) && (op == OP_RD);
  assign wr   = (state == BUS) && (op == OP_WR);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (rx_valid) state_nx = is_cmd(rx_data) ? ADDR : RESP;
      ADDR:    if (field_done)     state_nx = (op == OP_WR) ? DATA : BUS;
               else if (timed_out) state_nx = IDLE;
      DATA:    if (field_done)     state_nx = BUS;
               else if (timed_out) state_nx = IDLE;
      BUS:     state_nx = RESP;
      RESP:    if (tx_ready) state_nx = TX_WAIT;
      TX_WAIT: if (hold_done && tx_ready)
                 state_nx = (resp_left == 3'd0) ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_resp  = 1'b0;
    resp_word  = {NAK_BYTE, 24'h0};
    resp_count = 3'd1;
    if (state == BUS) begin
      load_resp = 1'b1;
      if (op == OP_WR) begin
        resp_word = {ACK_BYTE, 24'h0};
      end else begin
        resp_word  = rdata;
        resp_count = 3'd4;
      end
    end else if (state == IDLE && rx_valid && !is_cmd(rx_data)) begin
      load_resp = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op       <= OP_RD;
      byte_cnt <= '0;
      idle_cnt <= '0;
      hold_cnt <= '0;
      addr     <= '0;
      wdata    <= '0;
      overrun  <= 1'b0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= send;

      unique case (state)
        IDLE: if (rx_valid && is_cmd(rx_data)) begin
          op       <= (rx_data == CMD_WR) ? OP_WR : OP_RD;
          byte_cnt <= '0;
        end
        ADDR, DATA: if (rx_valid) begin
          if (state == ADDR) addr  <= {addr[23:0], rx_data};
          else               wdata <= {wdata[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        BUS, RESP, TX_WAIT: if (rx_valid) overrun <= 1'b1;
        default: ;
      endcase

      if ((state == ADDR || state == DATA) && !rx_valid && !timed_out)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;

      if (state != TX_WAIT)  hold_cnt <= '0;
      else if (!hold_done)   hold_cnt <= hold_cnt + 1'b1;
    end
  end

  uart_bridge_resp_shifter u_resp (
    .clk        (clk),
    .reset      (reset),
    .load       (load_resp),
    .load_word  (resp_word),
    .load_count (resp_count),
    .shift      (send),
    .tx_data    (tx_data),
    .remaining  (resp_left)
  );

endmodule
